// File: rtl/noc_pkg.sv
// Shared NoC constants and types used by the output arbiter and crossbar schedulers.
package noc_pkg;

    localparam int NOC_PORTS = 16;
    localparam int FLIT_W    = 16;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic              last;
        logic [FLIT_W-1:0] data;
    } flit_t;

endpackage

// File: rtl/noc_rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping modulo N.
module noc_rr_pick #(
    parameter int N  = 16,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] idx,
    output logic [N-1:0]  onehot
);

    logic [N-1:0] rot;

    // rot[j] is request (ptr + j) mod N, so bit 0 has the highest priority.
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                any    = 1'b1;
                idx    = PW'((int'(ptr) + j) % N);
                onehot = N'(1) << PW'((int'(ptr) + j) % N);
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole output-port arbiter: round-robin per packet, grant held to the tail flit,
// one registered output stage with valid/ready backpressure.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no packet in progress; rotating pick among valid requesters
// ST_LOCKED  | owner is mid-packet; only owner may send until its tail flit
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter int N      = NOC_PORTS,
    parameter int FLIT_W = noc_pkg::FLIT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 req_valid_i,
    input  logic [N-1:0][FLIT_W-1:0]     req_data_i,
    input  logic [N-1:0]                 req_last_i,
    output logic [N-1:0]                 req_ready_o,
    output logic                         out_valid_o,
    output logic [FLIT_W-1:0]            out_data_o,
    output logic                         out_last_o,
    input  logic                         out_ready_i,
    output logic [N-1:0]                 grant_o,
    output logic                         busy_o
);

    localparam int PW = $clog2(N);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]    state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;

    logic          pick_any;
    logic [PW-1:0] pick_idx;
    logic [N-1:0]  pick_onehot;

    logic          can_load;
    logic          accept;
    logic [PW-1:0] sel;
    logic [PW-1:0] sel_next;

    noc_rr_pick #(.N(N), .PW(PW)) u_pick (
        .req    (req_valid_i),
        .ptr    (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign can_load = !out_valid_o || out_ready_i;
    assign sel      = (state == ST_LOCKED) ? owner : pick_idx;
    assign sel_next = (sel == PW'(N - 1)) ? '0 : sel + PW'(1);
    assign busy_o   = (state == ST_LOCKED);
    assign grant_o  = (state == ST_LOCKED) ? (N'(1) << owner) : '0;

    // Ready is gated by rst so nothing looks accepted while reset is held.
    always_comb begin
        req_ready_o = '0;
        if (rst && can_load) begin
            if (state == ST_LOCKED)
                req_ready_o = N'(1) << owner;
            else
                req_ready_o = pick_onehot;
        end
    end

    assign accept = rst && can_load &&
                    ((state == ST_LOCKED) ? req_valid_i[owner] : pick_any);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            out_data_o  <= req_data_i[sel];
            out_last_o  <= req_last_i[sel];
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else if (accept) begin
            if (req_last_i[sel]) begin
                state  <= ST_IDLE;
                rr_ptr <= sel_next;
            end else if (state == ST_IDLE) begin
                state <= ST_LOCKED;
                owner <= sel;
            end
        end
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed table-driven bench for noc_output_arbiter plus an async-reset sequence.
module tb_noc_output_arbiter;

    localparam int N = 16;
    localparam int W = 16;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req_valid_i;
    logic [N-1:0][W-1:0]  req_data_i;
    logic [N-1:0]         req_last_i;
    logic [N-1:0]         req_ready_o;
    logic                 out_valid_o;
    logic [W-1:0]         out_data_o;
    logic                 out_last_o;
    logic                 out_ready_i;
    logic [N-1:0]         grant_o;
    logic                 busy_o;

    int total = 0;
    int bad   = 0;

    noc_output_arbiter #(.N(N), .FLIT_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs driven in a cycle; registered outputs reflect the previous cycle's accept.
    typedef struct packed {
        logic [15:0] valid;
        logic [15:0] last;
        logic [11:0] seq;
        logic        ordy;
        logic [15:0] ready;
        logic        ov;
        logic [15:0] od;
        logic        ol;
        logic [15:0] gnt;
        logic        bsy;
    } vec_t;

    vec_t vecs [25];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Requester i always presents data {i, seq}.
    task automatic drive(input logic [15:0] v, input logic [15:0] l, input logic [11:0] s,
                         input logic r);
        req_valid_i = v;
        req_last_i  = l;
        out_ready_i = r;
        for (int i = 0; i < N; i++) req_data_i[i] = {4'(i), s};
    endtask

    initial begin
        //            valid    last     seq    ordy  ready    ov    od        ol    gnt      bsy
        // ping-pong between single-flit requesters 0 and 3
        vecs[0]  = '{16'h0009, 16'h0009, 12'd1, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{16'h0009, 16'h0009, 12'd2, 1'b1, 16'h0008, 1'b1, 16'h0001, 1'b1, 16'h0000, 1'b0};
        vecs[2]  = '{16'h0009, 16'h0009, 12'd3, 1'b1, 16'h0001, 1'b1, 16'h3002, 1'b1, 16'h0000, 1'b0};
        vecs[3]  = '{16'h0009, 16'h0009, 12'd4, 1'b1, 16'h0008, 1'b1, 16'h0003, 1'b1, 16'h0000, 1'b0};
        // 4-flit packet from 5 while 2 keeps asking
        vecs[4]  = '{16'h0024, 16'h0004, 12'd1, 1'b1, 16'h0020, 1'b1, 16'h3004, 1'b1, 16'h0000, 1'b0};
        vecs[5]  = '{16'h0024, 16'h0004, 12'd2, 1'b1, 16'h0020, 1'b1, 16'h5001, 1'b0, 16'h0020, 1'b1};
        vecs[6]  = '{16'h0024, 16'h0004, 12'd3, 1'b1, 16'h0020, 1'b1, 16'h5002, 1'b0, 16'h0020, 1'b1};
        vecs[7]  = '{16'h0024, 16'h0024, 12'd4, 1'b1, 16'h0020, 1'b1, 16'h5003, 1'b0, 16'h0020, 1'b1};
        vecs[8]  = '{16'h0004, 16'h0004, 12'd5, 1'b1, 16'h0004, 1'b1, 16'h5004, 1'b1, 16'h0000, 1'b0};
        // downstream stalls three cycles
        vecs[9]  = '{16'h0002, 16'h0002, 12'd6, 1'b0, 16'h0000, 1'b1, 16'h2005, 1'b1, 16'h0000, 1'b0};
        vecs[10] = '{16'h0002, 16'h0002, 12'd6, 1'b0, 16'h0000, 1'b1, 16'h2005, 1'b1, 16'h0000, 1'b0};
        vecs[11] = '{16'h0002, 16'h0002, 12'd6, 1'b0, 16'h0000, 1'b1, 16'h2005, 1'b1, 16'h0000, 1'b0};
        vecs[12] = '{16'h0002, 16'h0002, 12'd6, 1'b1, 16'h0002, 1'b1, 16'h2005, 1'b1, 16'h0000, 1'b0};
        vecs[13] = '{16'h0000, 16'h0000, 12'd0, 1'b1, 16'h0000, 1'b1, 16'h1006, 1'b1, 16'h0000, 1'b0};
        vecs[14] = '{16'h0000, 16'h0000, 12'd0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        // move pointer to 15, then 15 and 0 compete across the wrap
        vecs[15] = '{16'h4000, 16'h4000, 12'd7, 1'b1, 16'h4000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[16] = '{16'h8001, 16'h8001, 12'd8, 1'b1, 16'h8000, 1'b1, 16'hE007, 1'b1, 16'h0000, 1'b0};
        vecs[17] = '{16'h8001, 16'h8001, 12'd9, 1'b1, 16'h0001, 1'b1, 16'hF008, 1'b1, 16'h0000, 1'b0};
        vecs[18] = '{16'h0000, 16'h0000, 12'd0, 1'b1, 16'h0000, 1'b1, 16'h0009, 1'b1, 16'h0000, 1'b0};
        // owner 7 goes quiet mid-packet while 1 waits
        vecs[19] = '{16'h0080, 16'h0000, 12'd1, 1'b1, 16'h0080, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[20] = '{16'h0002, 16'h0002, 12'd2, 1'b1, 16'h0080, 1'b1, 16'h7001, 1'b0, 16'h0080, 1'b1};
        vecs[21] = '{16'h0002, 16'h0002, 12'd2, 1'b1, 16'h0080, 1'b0, 16'h0000, 1'b0, 16'h0080, 1'b1};
        vecs[22] = '{16'h0082, 16'h0082, 12'd3, 1'b1, 16'h0080, 1'b0, 16'h0000, 1'b0, 16'h0080, 1'b1};
        vecs[23] = '{16'h0002, 16'h0002, 12'd4, 1'b1, 16'h0002, 1'b1, 16'h7003, 1'b1, 16'h0000, 1'b0};
        vecs[24] = '{16'h0000, 16'h0000, 12'd0, 1'b1, 16'h0000, 1'b1, 16'h1004, 1'b1, 16'h0000, 1'b0};

        rst = 1'b0;
        drive(16'h0009, 16'h0009, 12'd0, 1'b1);
        #12;
        check("rst_ready",  32'(req_ready_o), 32'h0);
        check("rst_ovalid", 32'(out_valid_o), 32'h0);
        check("rst_odata",  32'(out_data_o),  32'h0);
        check("rst_grant",  32'(grant_o),     32'h0);
        check("rst_busy",   32'(busy_o),      32'h0);
        drive(16'h0000, 16'h0000, 12'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            drive(vecs[k].valid, vecs[k].last, vecs[k].seq, vecs[k].ordy);
            #1;
            check($sformatf("v%0d_ready", k),  32'(req_ready_o), 32'(vecs[k].ready));
            check($sformatf("v%0d_ovalid", k), 32'(out_valid_o), 32'(vecs[k].ov));
            check($sformatf("v%0d_grant", k),  32'(grant_o),     32'(vecs[k].gnt));
            check($sformatf("v%0d_busy", k),   32'(busy_o),      32'(vecs[k].bsy));
            if (vecs[k].ov) begin
                check($sformatf("v%0d_odata", k), 32'(out_data_o), 32'(vecs[k].od));
                check($sformatf("v%0d_olast", k), 32'(out_last_o), 32'(vecs[k].ol));
            end
        end

        // async reset while LOCKED with a flit in the output register; pointer is 2 here
        @(negedge clk);
        drive(16'h0010, 16'h0000, 12'd1, 1'b1);
        @(negedge clk);
        drive(16'h0010, 16'h0000, 12'd2, 1'b1);
        #1;
        check("pre_rst_busy",   32'(busy_o),      32'h1);
        check("pre_rst_grant",  32'(grant_o),     32'h0010);
        check("pre_rst_ovalid", 32'(out_valid_o), 32'h1);
        check("pre_rst_odata",  32'(out_data_o),  32'h4001);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_ovalid", 32'(out_valid_o), 32'h0);
        check("arst_grant",  32'(grant_o),     32'h0);
        check("arst_busy",   32'(busy_o),      32'h0);
        check("arst_ready",  32'(req_ready_o), 32'h0);
        drive(16'h0011, 16'h0011, 12'd3, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_ready", 32'(req_ready_o), 32'h0001);
        check("post_rst_busy",  32'(busy_o),      32'h0);
        @(negedge clk);
        #1;
        check("post_rst_odata", 32'(out_data_o),  32'h0003);
        check("post_rst_ready2", 32'(req_ready_o), 32'h0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
